// File: rtl/inst_queue_pkg.sv
// Shared widths and decode field positions for the fetch-to-decode instruction queue.
// The opcode decoder imports the same field constants so both blocks agree on rd/rj/rk placement.
package inst_queue_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam int REG_W  = 5;

    localparam int RD_LSB = 0;
    localparam int RJ_LSB = 5;
    localparam int RK_LSB = 10;

    localparam int ID_TO_SP_BUS_W = 3 * REG_W + INST_W;  // 47

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } iq_entry_t;

    // Decode-side bus layout: {rk, rj, rd, inst}
    function automatic logic [ID_TO_SP_BUS_W-1:0] pack_id_bus(input logic [INST_W-1:0] inst);
        return {inst[RK_LSB +: REG_W], inst[RJ_LSB +: REG_W], inst[RD_LSB +: REG_W], inst};
    endfunction

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer with
// registered occupancy, flush/reset discard and zeroed outputs when empty.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush_i,
    input  logic                      if_valid_i,
    input  logic [INST_W-1:0]         if_inst_i,
    input  logic [PC_W-1:0]           if_pc_i,
    output logic                      if_allowin_o,
    input  logic                      id_allowin_i,
    output logic                      id_valid_o,
    output logic [ID_TO_SP_BUS_W-1:0] to_id_obus,
    output logic [PC_W-1:0]           id_pc_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    iq_entry_t     mem [DEPTH];
    iq_entry_t     head;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    // Full blocks pushes outright; a same-cycle pop does not free a slot early.
    assign if_allowin_o = (count < FULL_CNT);
    assign id_valid_o   = (count != '0);
    assign count_o      = count;

    assign push = rst_n && !flush_i && if_valid_i && if_allowin_o;
    assign pop  = rst_n && !flush_i && id_allowin_i && id_valid_o;

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: if_pc_i, inst: if_inst_i};
    end

    assign head = mem[rd_ptr];

    always_comb begin
        to_id_obus = '0;
        id_pc_o    = '0;
        if (id_valid_o) begin
            to_id_obus = pack_id_bus(head.inst);
            id_pc_o    = head.pc;
        end
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered instruction entries (power of two, minimum 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 flush_i  input  1  pipeline flush (branch/exception redirect); discards all entries.
REQ-005 if_valid_i  input  1  fetch stage presents a valid instruction.
REQ-006 if_inst_i  input  32  fetched instruction word.
REQ-007 if_pc_i  input  32  PC of fetched instruction.
REQ-008 if_allowin_o  output  1  queue accepts a push this cycle.
REQ-009 id_allowin_i  input  1  decode stage consumes head entry this cycle.
REQ-010 id_valid_o  output  1  head entry valid toward decode.
REQ-011 to_id_obus  output  `IdToSpBusWidth (47)  packed {rk, rj, rd, inst} of head entry, rk/rj/rd 5 bits each.
REQ-012 id_pc_o  output  32  PC of head entry.
REQ-013 count_o  output  log2(DEPTH)+1  current occupancy.

Function
REQ-014 Push SHALL occur when if_valid_i && if_allowin_o && !flush_i; entry stores {pc, inst}.
REQ-015 Pop SHALL occur when id_valid_o && id_allowin_i && !flush_i; head pointer advances by one.
REQ-016 if_allowin_o SHALL equal (count_o < DEPTH); no pass-through when full, even if pop occurs same cycle.
REQ-017 id_valid_o SHALL equal (count_o != 0); no same-cycle bypass of a push — push in cycle N visible at output in cycle N+1 (latency 1).
REQ-018 Simultaneous push and pop SHALL leave count_o unchanged and move both pointers.
REQ-019 Field extraction SHALL be rd = inst[4:0], rj = inst[9:5], rk = inst[14:10], taken from the head entry's stored word.
REQ-020 to_id_obus and id_pc_o SHALL be combinational from the head entry; when empty they SHALL be driven to all zeros.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH nor underflow below 0.
REQ-022 flush_i SHALL take priority over push and pop in the same cycle: next cycle count_o = 0, pointers = 0, id_valid_o = 0; a coincident fetch is dropped.
REQ-023 Entries SHALL be delivered strictly in push order; storage contents SHALL not be altered except by push.

Reset
REQ-024 While rst_n is low at a rising edge: read/write pointers = 0, count_o = 0, id_valid_o = 0, if_allowin_o = 1 from the following cycle, to_id_obus = 0, id_pc_o = 0.
REQ-025 Reset asserted mid-operation SHALL discard all stored entries exactly as a flush; storage array need not be cleared.

Structure
REQ-026 Bus widths (`IdToSpBusWidth, PC width, instruction width) SHALL be defined in the shared DefineLoogLenWidth.h header, not locally.
REQ-027 Field bit positions of rd/rj/rk SHALL be shared header constants so this block and the opcode decoder agree.
REQ-028 No sub-module required; storage, pointers and occupancy counter SHALL be in one module.

Verification
REQ-029 Reset then push 0x02800C21 pc 0x1C000000, id_allowin_i=0 -> next cycle id_valid_o=1, rd=1, rj=1, rk=3, id_pc_o=0x1C000000, count_o=1.
REQ-030 Push DEPTH instructions with id_allowin_i=0 -> count_o=DEPTH, if_allowin_o=0; fifth if_valid_i ignored; draining yields original order.
REQ-031 Full queue, push and pop same cycle -> pop accepted, push rejected, count_o=DEPTH-1 next cycle.
REQ-032 count=2, push and pop same cycle repeatedly for 2*DEPTH cycles -> count_o stays 2, pointers wrap, order preserved.
REQ-033 count=3, flush_i with if_valid_i=1 and id_allowin_i=1 -> next cycle count_o=0, id_valid_o=0, to_id_obus=0.
REQ-034 count=2, rst_n low one cycle -> next cycle count_o=0, id_valid_o=0, if_allowin_o=1.
